// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, handshakes with imem via ihit, and feeds IF/ID.
// Optional FETCH_SKID_EN adds a one-entry skid buffer (HOLD state) for words returned under stall.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instr_out,
    output logic [31:0] pcout_out,
    output logic        enable_out,
    output logic        flush_out,
    output logic        halted
);

`ifdef FETCH_SKID_EN
    typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;
`else
    typedef enum logic [1:0] {FETCH, HALTED} state_t;
`endif

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_inc;
    logic [31:0] pc_tgt;

    assign pc_inc = pc_q + PC_STEP;
    assign pc_tgt = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_SKID_EN
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
`endif

    // Outputs are combinational so an ihit is forwarded to IF/ID in the same cycle.
    always_comb begin
        imemREN    = 1'b0;
        imemaddr   = 32'h0;
        instr_out  = 32'h0;
        pcout_out  = 32'h0;
        enable_out = 1'b0;
        flush_out  = 1'b0;
        halted     = 1'b0;
        if (!RST) begin
            imemaddr  = pc_q & 32'hFFFF_FFFC;
            instr_out = imemload;
            pcout_out = pc_inc;
            case (state_q)
                FETCH: begin
                    imemREN    = 1'b1;
                    enable_out = ihit & !stall & !redirect & !halt;
                    flush_out  = redirect & !halt;
                end
`ifdef FETCH_SKID_EN
                HOLD: begin
                    instr_out  = skid_instr_q;
                    pcout_out  = skid_pc_q;
                    enable_out = !stall & !redirect & !halt;
                    flush_out  = redirect & !halt;
                end
`endif
                HALTED: halted = 1'b1;
                default: ;
            endcase
        end
    end

    // Priority in every live state: halt, then redirect, then the fetch/stall handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
`ifdef FETCH_SKID_EN
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
`endif
        end else begin
            case (state_q)
                FETCH: begin
                    if (halt) begin
                        state_q <= HALTED;
                    end else if (redirect) begin
                        pc_q <= pc_tgt;
                    end else if (ihit && !stall) begin
                        pc_q <= pc_inc;
                    end
`ifdef FETCH_SKID_EN
                    else if (ihit && stall) begin
                        skid_instr_q <= imemload;
                        skid_pc_q    <= pc_inc;
                        state_q      <= HOLD;
                    end
`endif
                end
`ifdef FETCH_SKID_EN
                HOLD: begin
                    if (halt) begin
                        state_q <= HALTED;
                    end else if (redirect) begin
                        pc_q    <= pc_tgt;
                        state_q <= FETCH;
                    end else if (!stall) begin
                        pc_q    <= pc_inc;
                        state_q <= FETCH;
                    end
                end
`endif
                HALTED: state_q <= HALTED;
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed per-cycle vector bench for fetch_stage, plus hand sequences for redirect-under-stall and mid-run reset.
module tb_fetch_stage;

`ifdef FETCH_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic        clk;
    logic        rst, ihit, stall, redirect, halt;
    logic [31:0] imemload, redirect_pc;
    logic        imemREN, enable_out, flush_out, halted;
    logic [31:0] imemaddr, instr_out, pcout_out;

    int tests = 0;
    int fails = 0;

    fetch_stage dut (
        .CLK(clk), .RST(rst), .ihit(ihit), .imemload(imemload), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr), .instr_out(instr_out),
        .pcout_out(pcout_out), .enable_out(enable_out), .flush_out(flush_out),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ihit, stall, redir, halt;
        logic [31:0] load, rpc;
        logic        e_ren, e_en, e_fl, e_hlt, cd;
        logic [31:0] e_addr, e_instr, e_pcout;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic ih, logic st, logic rd, logic hl,
                                logic [31:0] ld, logic [31:0] rp,
                                logic ren, logic en, logic fl, logic hlt, logic cd,
                                logic [31:0] addr, logic [31:0] pco);
        vec_t v;
        v.rst = r; v.ihit = ih; v.stall = st; v.redir = rd; v.halt = hl;
        v.load = ld; v.rpc = rp;
        v.e_ren = ren; v.e_en = en; v.e_fl = fl; v.e_hlt = hlt; v.cd = cd;
        v.e_addr = addr; v.e_instr = r ? 32'h0 : ld; v.e_pcout = pco;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ih, input logic st, input logic rd,
                         input logic hl, input logic [31:0] ld, input logic [31:0] rp);
        rst = r; ihit = ih; stall = st; redirect = rd; halt = hl;
        imemload = ld; redirect_pc = rp;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        //          rst ih st rd hl load          rpc           ren     en fl ht cd addr          pcout
        vq.push_back(mk(1, 1, 0, 0, 0, 32'h1111_0000, 32'h0,       0,      0, 0, 0, 1, 32'h0,        32'h0));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hA000_0000, 32'h0,       1,      1, 0, 0, 1, 32'h0,        32'h4));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hA000_0004, 32'h0,       1,      1, 0, 0, 1, 32'h4,        32'h8));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hA000_0008, 32'h0,       1,      1, 0, 0, 1, 32'h8,        32'hC));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hA000_000C, 32'h0,       1,      1, 0, 0, 1, 32'hC,        32'h10));
        // ihit withheld for three cycles at pc=0x10
        vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,       1,      0, 0, 0, 1, 32'h10,       32'h14));
        vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,       1,      0, 0, 0, 1, 32'h10,       32'h14));
        vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,       1,      0, 0, 0, 1, 32'h10,       32'h14));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'h0000_1234, 32'h0,       1,      1, 0, 0, 1, 32'h10,       32'h14));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hA000_0014, 32'h0,       1,      1, 0, 0, 1, 32'h14,       32'h18));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hA000_0018, 32'h0,       1,      1, 0, 0, 1, 32'h18,       32'h1C));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hA000_001C, 32'h0,       1,      1, 0, 0, 1, 32'h1C,       32'h20));
        // ihit under stall at pc=0x20 for two cycles; skid build holds the word with imemREN low
        vq.push_back(mk(0, 1, 1, 0, 0, 32'h8C22_0004, 32'h0,       1,      0, 0, 0, 1, 32'h20,       32'h24));
        vq.push_back(mk(0, 1, 1, 0, 0, 32'h8C22_0004, 32'h0,       !SKID,  0, 0, 0, 1, 32'h20,       32'h24));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'h8C22_0004, 32'h0,       !SKID,  1, 0, 0, 1, 32'h20,       32'h24));
        // redirect with ihit: target low bits cleared
        vq.push_back(mk(0, 1, 0, 1, 0, 32'hA000_0024, 32'h0000_0103, 1,    0, 1, 0, 1, 32'h24,       32'h28));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hA000_0100, 32'h0,       1,      1, 0, 0, 1, 32'h100,      32'h104));
        vq.push_back(mk(0, 0, 0, 1, 0, 32'h0,         32'hFFFF_FFFC, 1,    0, 1, 0, 1, 32'h104,      32'h108));
        // accepted fetch at top of address space wraps to 0
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hA0FF_FFFC, 32'h0,       1,      1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0));
        vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,       1,      0, 0, 0, 1, 32'h0,        32'h4));
        // halt beats redirect and ihit; HALTED ignores everything but reset
        vq.push_back(mk(0, 1, 0, 1, 1, 32'hA000_0000, 32'h0000_0200, 1,    0, 0, 0, 1, 32'h0,        32'h4));
        vq.push_back(mk(0, 1, 0, 1, 0, 32'hA000_0000, 32'h0000_0300, 0,    0, 0, 1, 0, 32'h0,        32'h0));
        vq.push_back(mk(0, 1, 1, 0, 0, 32'hA000_0000, 32'h0,       0,      0, 0, 1, 0, 32'h0,        32'h0));
        vq.push_back(mk(1, 1, 0, 0, 0, 32'hA000_0000, 32'h0,       0,      0, 0, 0, 1, 32'h0,        32'h0));
        vq.push_back(mk(0, 1, 0, 0, 0, 32'hB000_0000, 32'h0,       1,      1, 0, 0, 1, 32'h0,        32'h4));

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].ihit, vq[i].stall, vq[i].redir, vq[i].halt, vq[i].load, vq[i].rpc);
            #1;
            chk($sformatf("v%0d imemREN", i),    {31'h0, imemREN},    {31'h0, vq[i].e_ren});
            chk($sformatf("v%0d enable_out", i), {31'h0, enable_out}, {31'h0, vq[i].e_en});
            chk($sformatf("v%0d flush_out", i),  {31'h0, flush_out},  {31'h0, vq[i].e_fl});
            chk($sformatf("v%0d halted", i),     {31'h0, halted},     {31'h0, vq[i].e_hlt});
            if (vq[i].cd) begin
                chk($sformatf("v%0d imemaddr", i),  imemaddr,  vq[i].e_addr);
                chk($sformatf("v%0d instr_out", i), instr_out, vq[i].e_instr);
                chk($sformatf("v%0d pcout_out", i), pcout_out, vq[i].e_pcout);
            end
        end

        // Redirect while stalled (pc=0x4 here): redirect wins over stall in both builds.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC0DE_0004, 32'h0);
        #1;
        chk("stall_hold enable_out", {31'h0, enable_out}, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC0DE_0004, 32'h0000_0042);
        #1;
        chk("redir_stall flush_out", {31'h0, flush_out}, 32'h1);
        chk("redir_stall enable_out", {31'h0, enable_out}, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("redir_stall imemaddr", imemaddr, 32'h40);
        chk("redir_stall imemREN", {31'h0, imemREN}, 32'h1);

        // Reset mid-operation with a stalled word in flight: everything cleared.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
        #1;
        chk("rst_mid imemREN", {31'h0, imemREN}, 32'h0);
        chk("rst_mid instr_out", instr_out, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_mid imemaddr", imemaddr, 32'h0);
        chk("rst_mid imemREN after", {31'h0, imemREN}, 32'h1);
        chk("rst_mid pcout_out", pcout_out, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the pipelined MIPS core; sits directly upstream of the IF/ID pipeline register and drives its instruction_in, pcout_in, enable and flush inputs.
- Owns the PC, issues instruction-memory read requests, and waits on the ihit handshake.
- Applies downstream stalls, branch/jump redirects and halt.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset.
- PC_STEP, 4, byte increment applied after each accepted fetch.

Ports:
- CLK  input  1  clock, rising-edge
- RST  input  1  reset, synchronous, active-high
- ihit  input  1  instruction memory has returned imemload for imemaddr this cycle
- imemload  input  32  instruction word from memory
- stall  input  1  IF/ID cannot accept this cycle (hazard/dcache stall)
- redirect  input  1  taken branch/jump/jr resolved downstream
- redirect_pc  input  32  target PC for redirect
- halt  input  1  halt instruction detected downstream
- imemREN  output  1  instruction read request
- imemaddr  output  32  instruction read address (current PC)
- instr_out  output  32  to IF/ID instruction_in
- pcout_out  output  32  to IF/ID pcout_in (fetch PC + PC_STEP)
- enable_out  output  1  to IF/ID enable; latch instr_out/pcout_out this edge
- flush_out  output  1  to IF/ID flush
- halted  output  1  fetch permanently stopped

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-high (RST).
- Reset values: pc=PC_INIT, state=FETCH. All outputs 0 during a cycle with RST high, including imemREN, enable_out, flush_out and halted. RST mid-operation discards any outstanding request and buffered word.
- States: FETCH, HOLD (exists only with FETCH_SKID_EN), HALTED.
- FETCH outputs: imemREN=1, imemaddr=pc, instr_out=imemload, pcout_out=pc+PC_STEP (mod 2^32, wraps silently).
- Accept condition: ihit & !stall & !redirect & !halt.
  - enable_out=1 combinationally in the same cycle as ihit (zero added latency).
  - pc <= pc+PC_STEP at the edge.
- ihit & stall:
  - Without FETCH_SKID_EN: word discarded, pc unchanged, request re-issued next cycle.
  - With FETCH_SKID_EN: see Optional Feature.
- Redirect (redirect=1, halt=0), from FETCH or HOLD:
  - pc <= {redirect_pc[31:2],2'b00}.
  - flush_out=1 this cycle; enable_out=0 and any returning ihit is ignored.
  - Any buffered word is dropped; next state FETCH.
- Redirect while stall=1: redirect still applies; it has priority over stall.
- Halt (halt=1, any state):
  - Next state HALTED; takes priority over redirect and ihit.
  - enable_out=0 and flush_out=0 this cycle.
- HALTED:
  - imemREN=0, enable_out=0, halted=1, pc frozen.
  - All inputs ignored; only RST exits.
- flush_out is asserted only on redirect. It is never asserted together with enable_out.
- imemaddr[1:0] is always 2'b00.

Optional Feature:
- Macro: FETCH_SKID_EN.
- Defined: one-entry skid buffer plus HOLD state.
  - ihit & stall in FETCH: capture imemload and pc+PC_STEP; next state HOLD; pc unchanged.
  - HOLD outputs: imemREN=0, instr_out/pcout_out driven from the buffer.
  - Leaving HOLD: first cycle with stall=0 gives enable_out=1, pc <= pc+PC_STEP, next state FETCH.
  - Redirect or halt in HOLD behaves as defined above.
- Undefined: HOLD state and buffer are absent; behaviour is exactly the discard/re-request rule.

Test Plan:
- Reset, PC_INIT=0, ihit=1 each cycle, stall=0: imemaddr sequence 0x0,0x4,0x8. enable_out=1 every cycle. pcout_out=0x4,0x8,0xC.
- ihit delayed 3 cycles at pc=0x10: imemREN=1 and imemaddr=0x10 held 3 cycles, enable_out=0. On the ihit cycle enable_out=1, instr_out=imemload, pcout_out=0x14.
- ihit with stall=1 at pc=0x20 for 2 cycles, instr 0x8C220004:
  - Without skid: imemaddr stays 0x20, enable_out=0 until stall drops, then enable_out=1 with the re-fetched word.
  - With skid: imemREN=0 during HOLD, then enable_out=1, instr_out=0x8C220004 on the first stall=0 cycle.
- redirect=1, redirect_pc=0x00000103, same cycle as ihit: flush_out=1, enable_out=0, next imemaddr=0x100.
- halt=1 and redirect=1 together: next state HALTED. halted=1, imemREN=0, flush_out=0. Further ihit/redirect ignored until RST.
- pc=0xFFFFFFFC accepted fetch: pcout_out=0x0, next imemaddr=0x0.
